// File: rtl/ign_channel.sv
// ----------------------------------------------------------------------------
// ign_channel -- angle-triggered ignition coil channel
//
// Drives one coil from a phase-synced crank/cam angle. The coil is charged
// (out = 1) from the angle edge that reaches the active set angle until the
// angle edge that reaches the active reset (spark) angle. An optional maximum
// dwell time cuts the charge early and latches a sticky timeout flag.
//
// New angles/dwell limits are written into a shadow register set and moved
// into the active set either immediately while the channel is idle or on the
// next cycle wrap. This keeps a dwell that is already in progress consistent.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   hwag_start     angle generator synchronized (0 = angle invalid)
//   angle          cycle angle, +1 per step or wraps TOP->0
//   wr             single-cycle strobe loading the shadow registers
//   set_angle_in   dwell start angle
//   reset_angle_in spark (dwell end) angle
//   dwell_max_in   maximum dwell in clk cycles, 0 = unlimited
//   clr            clears the sticky tmo/err flags
//   out            registered coil drive, 1 = dwell
//   pending        shadow holds values not yet moved to the active set
//   tmo            sticky: a dwell was cut by the timeout
//   err            sticky: a write was rejected (angle > TOP)
// ----------------------------------------------------------------------------
module ign_channel #(
  parameter int AW  = 24,
  parameter int TOP = 7679,
  parameter int TW  = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hwag_start,
  input  logic [AW-1:0] angle,
  input  logic          wr,
  input  logic [AW-1:0] set_angle_in,
  input  logic [AW-1:0] reset_angle_in,
  input  logic [TW-1:0] dwell_max_in,
  input  logic          clr,
  output logic          out,
  output logic          pending,
  output logic          tmo,
  output logic          err
);

  localparam logic [AW-1:0] TOP_V = AW'(TOP);
  localparam logic [TW-1:0] TIMER_SAT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DWELL = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] angle_q;
  logic [TW-1:0] timer_reg;

  logic [AW-1:0] set_shd, reset_shd;
  logic [TW-1:0] max_shd;
  logic [AW-1:0] set_act, reset_act;
  logic [TW-1:0] max_act;

  logic step, wrap, set_hit, rst_hit;
  logic wr_ok, xfer, timeout;

  // Angle edge detection. Hits only fire on the edge where the angle arrives
  // at a value, so a stalled angle cannot retrigger.
  assign step    = (angle != angle_q);
  assign wrap    = step & (angle == '0);
  assign set_hit = step & (angle == set_act);
  assign rst_hit = step & (angle == reset_act);

  assign wr_ok = wr & (set_angle_in <= TOP_V) & (reset_angle_in <= TOP_V);
  // Hits above use the pre-transfer active values, so a transfer on the wrap
  // edge only affects decisions from the following step onward.
  assign xfer  = pending & ((state_reg == IDLE) | wrap);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      IDLE:  state_next = ARMED;
      // set==reset makes both hits coincide, which keeps the channel parked.
      ARMED: if (set_hit && !rst_hit) state_next = DWELL;
      DWELL: begin
        if (rst_hit) begin
          state_next = ARMED;
        end else if ((max_act != '0) && (timer_reg == (max_act - TW'(1)))) begin
          state_next = LOCK;
          timeout    = 1'b1;
        end
      end
      LOCK:  if (rst_hit) state_next = ARMED;
      default: state_next = IDLE;
    endcase
    // Loss of angle sync overrides everything, including a pending timeout.
    if (!hwag_start) begin
      state_next = IDLE;
      timeout    = 1'b0;
    end
  end

  // State, angle history, dwell timer and coil drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      angle_q   <= '0;
      timer_reg <= '0;
      out       <= 1'b0;
    end else begin
      state_reg <= state_next;
      angle_q   <= angle;
      out       <= (state_next == DWELL);
      if (state_reg != DWELL && state_next == DWELL) begin
        timer_reg <= '0;
      end else if (state_reg == DWELL && timer_reg != TIMER_SAT) begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

  // Shadow/active register sets and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_shd   <= '0;
      reset_shd <= '0;
      max_shd   <= '0;
      set_act   <= '0;
      reset_act <= '0;
      max_act   <= '0;
      pending   <= 1'b0;
      tmo       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (xfer) begin
        set_act   <= set_shd;
        reset_act <= reset_shd;
        max_act   <= max_shd;
      end
      // A valid write on the transfer edge refills the shadow, so pending
      // stays set while the old shadow moves to active.
      if (wr_ok) begin
        set_shd   <= set_angle_in;
        reset_shd <= reset_angle_in;
        max_shd   <= dwell_max_in;
        pending   <= 1'b1;
      end else if (xfer) begin
        pending   <= 1'b0;
      end
      // Setting events beat clr on the same edge.
      if (wr && !wr_ok) err <= 1'b1;
      else if (clr)     err <= 1'b0;
      if (timeout)      tmo <= 1'b1;
      else if (clr)     tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ign_channel.sv
// ----------------------------------------------------------------------------
// tb_ign_channel -- scoreboard bench for ign_channel
//
// The driver applies inputs on the falling edge and asks a behavioural model
// what the outputs must look like after the next rising edge; that
// expectation is queued. An independent monitor pops one entry after every
// rising edge and compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_ign_channel;

  localparam int AW  = 24;
  localparam int TOP = 7679;
  localparam int TW  = 24;
  localparam logic [AW-1:0] TOP_A = AW'(TOP);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hwag_start = 1'b0;
  logic [AW-1:0] angle = '0;
  logic          wr = 1'b0;
  logic [AW-1:0] set_angle_in = '0;
  logic [AW-1:0] reset_angle_in = '0;
  logic [TW-1:0] dwell_max_in = '0;
  logic          clr = 1'b0;
  logic          out, pending, tmo, err;

  ign_channel #(.AW(AW), .TOP(TOP), .TW(TW)) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .angle(angle),
    .wr(wr), .set_angle_in(set_angle_in), .reset_angle_in(reset_angle_in),
    .dwell_max_in(dwell_max_in), .clr(clr),
    .out(out), .pending(pending), .tmo(tmo), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit o, p, t, e;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ---------------- behavioural model ----------------
  bit m_sync, m_dwell, m_lock, m_pend, m_tmo, m_err;
  int m_cnt, m_prev;
  int sh_set, sh_rst, sh_max, ac_set, ac_rst, ac_max;

  task automatic model_reset();
    m_sync = 0; m_dwell = 0; m_lock = 0; m_pend = 0; m_tmo = 0; m_err = 0;
    m_cnt = 0; m_prev = 0;
    sh_set = 0; sh_rst = 0; sh_max = 0; ac_set = 0; ac_rst = 0; ac_max = 0;
  endtask

  task automatic model_step();
    int  a;
    bit  moved, sh, rh, wrapped, idle, ok, fire;
    exp_t e;
    a       = int'(angle);
    moved   = (a != m_prev);
    sh      = moved && (a == ac_set);
    rh      = moved && (a == ac_rst);
    wrapped = moved && (a == 0);
    idle    = !m_sync;
    ok      = wr && (int'(set_angle_in) <= TOP) && (int'(reset_angle_in) <= TOP);
    fire    = 0;
    if (!hwag_start) begin
      m_sync = 0; m_dwell = 0; m_lock = 0;
    end else if (idle) begin
      m_sync = 1;
    end else if (m_dwell) begin
      if (rh) m_dwell = 0;
      else if (ac_max != 0 && m_cnt == ac_max - 1) begin
        m_dwell = 0; m_lock = 1; fire = 1;
      end else if (m_cnt < (1 << TW) - 1) m_cnt++;
    end else if (m_lock) begin
      if (rh) m_lock = 0;
    end else if (sh && !rh) begin
      m_dwell = 1; m_cnt = 0;
    end
    if (m_pend && (idle || wrapped)) begin
      ac_set = sh_set; ac_rst = sh_rst; ac_max = sh_max; m_pend = 0;
    end
    if (ok) begin
      sh_set = int'(set_angle_in); sh_rst = int'(reset_angle_in);
      sh_max = int'(dwell_max_in); m_pend = 1;
    end
    if (wr && !ok) m_err = 1; else if (clr) m_err = 0;
    if (fire)      m_tmo = 1; else if (clr) m_tmo = 0;
    m_prev = a;
    e.o = m_dwell; e.p = m_pend; e.t = m_tmo; e.e = m_err; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic cmp(string name, int c, int got, int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, got, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("out",     e.cyc, int'(out),     int'(e.o));
        cmp("pending", e.cyc, int'(pending), int'(e.p));
        cmp("tmo",     e.cyc, int'(tmo),     int'(e.t));
        cmp("err",     e.cyc, int'(err),     int'(e.e));
        $display("cyc=%0d ang=%0d out=%0b pend=%0b tmo=%0b err=%0b",
                 e.cyc, angle, out, pending, tmo, err);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    wr  = 1'b0;
    clr = 1'b0;
    cyc++;
  endtask

  task automatic next_angle();
    angle = (angle == TOP_A) ? '0 : angle + 1'b1;
  endtask

  task automatic adv_to(int target);
    while (int'(angle) != target) begin
      next_angle();
      tick();
    end
  endtask

  task automatic write(int s, int r, int m);
    wr             = 1'b1;
    set_angle_in   = AW'(s);
    reset_angle_in = AW'(r);
    dwell_max_in   = TW'(m);
  endtask

  // Load through IDLE so the new values become active straight away.
  task automatic load_idle(int s, int r, int m);
    hwag_start = 1'b0;
    write(s, r, m);
    tick();
    tick();
    hwag_start = 1'b1;
  endtask

  function automatic int pick_ang();
    if ($urandom_range(0, 19) == 0) return TOP + 1 + int'($urandom_range(0, 200));
    return (int'(angle) + int'($urandom_range(1, 150))) % (TOP + 1);
  endfunction

  // ---------------- main sequence ----------------
  initial begin : driver
    int s, r;
    model_reset();
    #12;
    cmp("rst_out",  cyc, int'(out), 0);
    cmp("rst_pend", cyc, int'(pending), 0);
    cmp("rst_tmo",  cyc, int'(tmo), 0);
    cmp("rst_err",  cyc, int'(err), 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic dwell 1152..1216 loaded while idle
    angle = AW'(1100);
    load_idle(1152, 1216, 0);
    adv_to(1300);

    // Rewrite mid-dwell: current dwell keeps old values until wrap
    adv_to(1100);
    adv_to(1180);
    write(2000, 2064, 0);
    next_angle();
    tick();
    adv_to(2100);

    // Timeout with stalled angle, then lock until reset angle, then rearm
    load_idle(1152, 1216, 10);
    adv_to(1153);
    repeat (30) tick();
    adv_to(1300);
    adv_to(1160);

    // Rejected write and clr
    write(7700, 100, 0);
    tick();
    repeat (3) tick();
    clr = 1'b1;
    tick();
    tick();

    // Dwell across wrap, then loss of sync mid-dwell
    load_idle(7660, 20, 0);
    adv_to(7600);
    adv_to(50);
    adv_to(7670);
    hwag_start = 1'b0;
    tick();
    tick();
    hwag_start = 1'b1;
    tick();

    // Asynchronous reset between clock edges while dwelling
    load_idle(100, 200, 0);
    adv_to(150);
    cmp("pre_rst_out", cyc, int'(out), int'(m_dwell));
    #2;
    rst = 1'b0;
    #1;
    cmp("arst_out",  cyc, int'(out), 0);
    cmp("arst_pend", cyc, int'(pending), 0);
    cmp("arst_tmo",  cyc, int'(tmo), 0);
    cmp("arst_err",  cyc, int'(err), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    hwag_start = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 99) < 80) next_angle();
      if ($urandom_range(0, 49) == 0) begin
        s = pick_ang();
        r = ($urandom_range(0, 9) == 0) ? s : pick_ang();
        write(s, r, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 200)));
      end
      if ($urandom_range(0, 99) == 0) clr = 1'b1;
      if (hwag_start && $urandom_range(0, 299) == 0) hwag_start = 1'b0;
      else if (!hwag_start && $urandom_range(0, 9) == 0) hwag_start = 1'b1;
      tick();
    end

    cmp("queue_drained", cyc, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ign_channel.md
IGN_CHANNEL -- requirements
Module: ign_channel

Interface
REQ-001 Parameter AW, 24, angle width in bits.
REQ-002 Parameter TOP, 7679, last angle value before wrap to 0 (720 deg cycle, 3840 steps per rev).
REQ-003 Parameter TW, 24, dwell timer width in bits.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 hwag_start  input  1  angle generator synchronized; 0 = angle invalid.
REQ-007 angle  input  AW  phase-synced cycle angle; changes by +1 or wraps TOP->0, at most once per clk.
REQ-008 wr  input  1  single-cycle strobe loading the shadow registers.
REQ-009 set_angle_in  input  AW  dwell start angle.
REQ-010 reset_angle_in  input  AW  spark (dwell end) angle.
REQ-011 dwell_max_in  input  TW  maximum dwell in clk cycles; 0 = unlimited.
REQ-012 clr  input  1  clears sticky flags tmo and err.
REQ-013 out  output  1  registered coil drive; 1 = dwell.
REQ-014 pending  output  1  shadow holds values not yet transferred to active.
REQ-015 tmo  output  1  sticky: dwell was cut by the timeout.
REQ-016 err  output  1  sticky: rejected write (angle > TOP).

Function
REQ-017 The block SHALL register angle into angle_q each clk; step = (angle != angle_q); wrap = step & (angle == 0).
REQ-018 set_hit SHALL be step & (angle == set_act); rst_hit SHALL be step & (angle == reset_act), using active registers only.
REQ-019 wr with set_angle_in > TOP or reset_angle_in > TOP: shadow unchanged, err = 1 next cycle.
REQ-020 Valid wr: shadow <= {set, reset, dwell_max} inputs, pending = 1 next cycle.
REQ-021 Transfer shadow->active SHALL occur when pending & (state == IDLE | wrap); pending cleared on that edge.
REQ-022 wr on the transfer edge: active takes the old shadow, shadow takes the new values, pending stays 1.
REQ-023 On a wrap edge with transfer, set_hit/rst_hit for angle 0 SHALL be evaluated against the new active values from the following step onward (old values on the wrap edge itself).
REQ-024 States: IDLE, ARMED, DWELL, LOCK.
REQ-025 IDLE: out = 0; hwag_start = 1 -> ARMED.
REQ-026 ARMED: set_hit -> DWELL, dwell timer cleared to 0; rst_hit ignored.
REQ-027 DWELL: timer increments each clk, saturating at 2^TW-1; rst_hit -> ARMED; set_hit ignored.
REQ-028 DWELL: dwell_max_act != 0 and timer == dwell_max_act-1 -> LOCK, tmo = 1 next cycle; rst_hit same cycle wins (-> ARMED, no tmo).
REQ-029 LOCK: out = 0; rst_hit -> ARMED (no refire in the same cycle); set_hit ignored.
REQ-030 Any state with hwag_start = 0 -> IDLE on the next edge, overriding all other transitions.
REQ-031 set_act == reset_act: set_hit and rst_hit coincide, ARMED stays ARMED; channel is effectively disabled.
REQ-032 out SHALL be a flop equal to (next state == DWELL): asserted 1 clk after the angle edge that reaches set_act, deasserted 1 clk after the edge reaching reset_act.
REQ-033 Dwell across wrap (set_act > reset_act) SHALL work without special handling.
REQ-034 clr clears tmo and err; a flag-setting event on the same edge wins (flag = 1).

Reset
REQ-035 rst low SHALL asynchronously force state IDLE, out 0, pending 0, tmo 0, err 0, shadow/active/timer/angle_q 0.
REQ-036 After rst releases, the first rising edge SHALL be the first state update; mid-dwell reset SHALL drop out immediately, without waiting for clk.

Verification
REQ-037 Bench SHALL cover: idle wr set=1152, reset=1216, max=0, hwag_start=1, angle ramp -> out high at angle 1152+1clk, low at 1216+1clk, pending 0 after 1 clk.
REQ-038 Bench SHALL cover: active 1152/1216; wr 2000/2064 at angle 1180 -> current dwell ends at 1216, pending = 1 until wrap, next cycle dwell 2000..2064.
REQ-039 Bench SHALL cover: max=10, angle stalled at 1153 after set -> out high exactly 10 clk, tmo = 1, out stays 0 until angle reaches 1216, then rearm on next 1152.
REQ-040 Bench SHALL cover: wr set=7700 -> err = 1, shadow/pending unchanged; clr -> err 0.
REQ-041 Bench SHALL cover: set=7660, reset=20 -> out high across 7679->0 wrap; hwag_start dropped mid-dwell -> out 0 next clk, state IDLE.
REQ-042 Bench SHALL cover: rst asserted low mid-dwell between clk edges -> out 0 asynchronously, all flags 0.
